// File: rtl/r22sdf_bitrev_16pt.sv
// r22sdf_bitrev_16pt: ping-pong reorder buffer that turns the bit-reversed
// output stream of a 16-point R2^2SDF FFT into natural bin order.
// Frame n is written into one bank while frame n-1 is read back from the
// other bank at the bit-reversed address, one output per accepted input.
// Optional macro BITREV_OUT_FF_EN adds one extra register stage on every
// output except sync_err.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | unsynchronised; discard samples until din_vld & din_sof
// FILL  | writing the first frame after sync, no output produced yet
// RUN   | writing frame n while emitting reordered frame n-1
module r22sdf_bitrev_16pt #(
    parameter int data_resolution = 16,
    parameter int fft_length      = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       din_vld,
    input  logic                       din_sof,
    input  logic [data_resolution-1:0] din_r,
    input  logic [data_resolution-1:0] din_i,
    output logic [data_resolution-1:0] dout_r,
    output logic [data_resolution-1:0] dout_i,
    output logic                       dout_vld,
    output logic                       dout_sof,
    output logic [3:0]                 dout_idx,
    output logic                       sync_err
);

    localparam int word_w = 2 * data_resolution;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [3:0]                   wr_cnt_q, wr_cnt_d;
    logic                         wr_bank_q, wr_bank_d;

    logic [word_w-1:0]            mem_q [0:1][0:fft_length-1];
    logic                         wr_en;
    logic [3:0]                   wr_addr;
    logic [word_w-1:0]            wr_word;
    logic [word_w-1:0]            rd_word;

    logic [data_resolution-1:0]   o1_r_q, o1_r_d;
    logic [data_resolution-1:0]   o1_i_q, o1_i_d;
    logic                         o1_vld_q, o1_vld_d;
    logic                         o1_sof_q, o1_sof_d;
    logic [3:0]                   o1_idx_q, o1_idx_d;
    logic                         sync_err_q, sync_err_d;

    // Position 0 and 15 are fixed points; bits 3<->0 and 2<->1 swap.
    function automatic logic [3:0] bitrev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    assign wr_word = {din_r, din_i};
    assign rd_word = mem_q[~wr_bank_q][bitrev4(wr_cnt_q)];

    // Next-state, write control and first output stage.
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        wr_en      = 1'b0;
        wr_addr    = wr_cnt_q;
        sync_err_d = 1'b0;
        o1_vld_d   = 1'b0;
        o1_r_d     = o1_r_q;
        o1_i_d     = o1_i_q;
        o1_sof_d   = o1_sof_q;
        o1_idx_d   = o1_idx_q;

        if (din_vld) begin
            case (state_q)
                IDLE: begin
                    if (din_sof) begin
                        wr_en    = 1'b1;
                        wr_addr  = 4'd0;
                        wr_cnt_d = 4'd1;
                        state_d  = FILL;
                    end
                end
                FILL, RUN: begin
                    if (din_sof && (wr_cnt_q != 4'd0)) begin
                        // Misaligned frame start: restart the current bank.
                        wr_en      = 1'b1;
                        wr_addr    = 4'd0;
                        wr_cnt_d   = 4'd1;
                        state_d    = FILL;
                        sync_err_d = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_cnt_d = wr_cnt_q + 4'd1;
                        if (wr_cnt_q == 4'd15) begin
                            wr_bank_d = ~wr_bank_q;
                            state_d   = RUN;
                        end
                        if (state_q == RUN) begin
                            o1_vld_d = 1'b1;
                            o1_r_d   = rd_word[word_w-1:data_resolution];
                            o1_i_d   = rd_word[data_resolution-1:0];
                            o1_idx_d = wr_cnt_q;
                            o1_sof_d = (wr_cnt_q == 4'd0);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and first output stage registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            wr_cnt_q   <= 4'd0;
            wr_bank_q  <= 1'b0;
            o1_r_q     <= '0;
            o1_i_q     <= '0;
            o1_vld_q   <= 1'b0;
            o1_sof_q   <= 1'b0;
            o1_idx_q   <= 4'd0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            o1_r_q     <= o1_r_d;
            o1_i_q     <= o1_i_d;
            o1_vld_q   <= o1_vld_d;
            o1_sof_q   <= o1_sof_d;
            o1_idx_q   <= o1_idx_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Ping-pong storage; contents survive reset, only the write is blocked.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && wr_en) begin
            mem_q[wr_bank_q][wr_addr] <= wr_word;
        end
    end

    assign sync_err = sync_err_q;

`ifdef BITREV_OUT_FF_EN
    logic [data_resolution-1:0]   o2_r_q, o2_r_d;
    logic [data_resolution-1:0]   o2_i_q, o2_i_d;
    logic                         o2_vld_q, o2_vld_d;
    logic                         o2_sof_q, o2_sof_d;
    logic [3:0]                   o2_idx_q, o2_idx_d;

    // Second output stage follows the first one unconditionally.
    always_comb begin
        o2_r_d   = o1_r_q;
        o2_i_d   = o1_i_q;
        o2_vld_d = o1_vld_q;
        o2_sof_d = o1_sof_q;
        o2_idx_d = o1_idx_q;
    end

    // Second output stage registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            o2_r_q   <= '0;
            o2_i_q   <= '0;
            o2_vld_q <= 1'b0;
            o2_sof_q <= 1'b0;
            o2_idx_q <= 4'd0;
        end else begin
            o2_r_q   <= o2_r_d;
            o2_i_q   <= o2_i_d;
            o2_vld_q <= o2_vld_d;
            o2_sof_q <= o2_sof_d;
            o2_idx_q <= o2_idx_d;
        end
    end

    assign dout_r   = o2_r_q;
    assign dout_i   = o2_i_q;
    assign dout_vld = o2_vld_q;
    assign dout_sof = o2_sof_q;
    assign dout_idx = o2_idx_q;
`else
    assign dout_r   = o1_r_q;
    assign dout_i   = o1_i_q;
    assign dout_vld = o1_vld_q;
    assign dout_sof = o1_sof_q;
    assign dout_idx = o1_idx_q;
`endif

endmodule
